ir_queue: RTL and testbench
===========================

IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 Parameter WIDTH, default 12: instruction word width in bits.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-003 Parameter OVERRIDE_WORD, default 12'o4000 zero-extended to WIDTH: word enqueued instead of busData when irqOverride is high.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 ckFetch  input  1  fetch strobe; only its rising edge enqueues.
REQ-007 irqOverride  input  1  sampled at the enqueue edge; selects OVERRIDE_WORD.
REQ-008 busData  input  WIDTH  fetched instruction word.
REQ-009 irTake  input  1  consumer pop request.
REQ-010 flush  input  1  synchronous queue clear.
REQ-011 busIR  output  WIDTH  head-of-queue word.
REQ-012 irValid  output  1  queue non-empty.
REQ-013 full  output  1  count equals DEPTH.
REQ-014 count  output  $clog2(DEPTH+1)  number of occupied entries.
REQ-015 overflow  output  1  sticky flag: an enqueue was dropped.
REQ-016 irqTaken  output  1  one-cycle pulse: OVERRIDE_WORD was enqueued.

Function
REQ-017 Edge detect: lastCkFetch is registered every cycle; push event = ckFetch & !lastCkFetch.
REQ-018 Push writes OVERRIDE_WORD if irqOverride, else busData, at the write pointer; the write pointer then increments.
REQ-019 Pop event = irTake & irValid; the read pointer increments; irTake while empty has no effect.
REQ-020 Both pointers wrap modulo DEPTH.
REQ-021 count updates as follows: push only +1; pop only -1; push and pop together unchanged.
REQ-022 Push while full and no pop in the same cycle: the word is dropped, pointers and count are unchanged, and overflow is set.
REQ-023 Push while full with a simultaneous pop: the push is accepted and the queue stays full.
REQ-024 Push while empty: the word becomes visible on busIR with irValid high on the next cycle; fill-to-visible latency is 1 cycle.
REQ-025 busIR is a combinational read of the head entry when irValid is high, and drives 0 when empty.
REQ-026 irqTaken is high for exactly the cycle after an accepted override push; it stays low for dropped pushes.
REQ-027 flush has priority over push and pop in the same cycle.
REQ-028 flush zeroes the pointers, count and overflow, and discards that cycle's push.
REQ-029 lastCkFetch still updates during a flush cycle.
REQ-030 overflow clears only on flush or reset.
REQ-031 irValid = (count != 0); full = (count == DEPTH).

Reset
REQ-032 When RESET is low, the following clear immediately and asynchronously to 0: pointers, count, lastCkFetch, overflow, irqTaken; busIR then reads 0.
REQ-033 Storage contents need not be reset.
REQ-034 If ckFetch is high in the first cycle after RESET deasserts, that cycle is a rising edge and causes a push.
REQ-035 If RESET asserts mid-operation, all queued words are lost; no pulse outputs fire on release.

Verification
REQ-036 Reset, then one ckFetch pulse with busData=12'o1234 -> next cycle busIR=12'o1234, irValid=1, count=1.
REQ-037 ckFetch held high for 5 cycles -> exactly one push, count=1.
REQ-038 DEPTH=4: 5 distinct pushes, no pops -> full=1, overflow=1, count=4; 4 pops return the first 4 words in FIFO order.
REQ-039 Full queue; push and pop in the same cycle -> count stays 4; the popped word is the oldest; the new word is at the tail.
REQ-040 Push with irqOverride=1 and busData=12'o7777 -> busIR=12'o4000 and a single-cycle irqTaken pulse.
REQ-041 Queue holding 3 words, then flush coinciding with a ckFetch edge -> count=0, irValid=0, overflow=0, busIR=0, no push.

Source files
------------

// File: rtl/ir_queue_if.sv
// rtl/ir_queue_if.sv - fetch/consume signal bundle for the instruction-register queue.
// The master side fetches and pops; the slave side is the queue itself.
interface ir_queue_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             ckFetch;
  logic             irqOverride;
  logic [WIDTH-1:0] busData;
  logic             irTake;
  logic             flush;
  logic [WIDTH-1:0] busIR;
  logic             irValid;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             irqTaken;

  modport master (
    output ckFetch, irqOverride, busData, irTake, flush,
    input  busIR, irValid, full, count, overflow, irqTaken
  );

  modport slave (
    input  ckFetch, irqOverride, busData, irTake, flush,
    output busIR, irValid, full, count, overflow, irqTaken
  );
endinterface

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - instruction-register FIFO fed on ckFetch rising edges.
// Pushes while full are dropped (sticky overflow) unless a pop frees the slot that cycle.
module ir_queue #(
  parameter int               WIDTH         = 12,
  parameter int               DEPTH         = 4,
  parameter logic [WIDTH-1:0] OVERRIDE_WORD = WIDTH'(12'o4000)
) (
  input logic         CLK,
  input logic         RESET,
  ir_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             last_ck_q;
  logic             overflow_q, overflow_d;
  logic             irq_taken_q, irq_taken_d;

  logic             push, pop, is_full, is_valid, accept;
  logic [WIDTH-1:0] push_word;

  assign is_valid  = (count_q != '0);
  assign is_full   = (count_q == CW'(DEPTH));
  assign push      = bus.ckFetch & ~last_ck_q;
  assign pop       = bus.irTake & is_valid;
  // A pop in the same cycle frees the head slot, so a full queue can still accept.
  assign accept    = push & (~is_full | pop) & ~bus.flush;
  assign push_word = bus.irqOverride ? OVERRIDE_WORD : bus.busData;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    irq_taken_d = 1'b0;
    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_d    = wr_ptr_q + PW'(1);
        irq_taken_d = bus.irqOverride;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (accept && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !accept) begin
        count_d = count_q - CW'(1);
      end
      if (push && !accept) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_ck_q   <= 1'b0;
      overflow_q  <= 1'b0;
      irq_taken_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_ck_q   <= bus.ckFetch;
      overflow_q  <= overflow_d;
      irq_taken_q <= irq_taken_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign bus.busIR    = is_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.irValid  = is_valid;
  assign bus.full     = is_full;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.irqTaken = irq_taken_q;
endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - scoreboard bench for ir_queue (WIDTH=12, DEPTH=4).
// Stimulus queues expected words; a negedge monitor checks each popped head.
module tb_ir_queue;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [11:0] expq [$];

  ir_queue_if #(.WIDTH(12), .DEPTH(4)) bus ();
  ir_queue #(.WIDTH(12), .DEPTH(4)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One rising edge on ckFetch followed by a low cycle.
  task automatic fetch(input logic [11:0] w, input logic irq, input logic expect_accept);
    bus.ckFetch = 1'b1;
    bus.busData = w;
    bus.irqOverride = irq;
    if (expect_accept) expq.push_back(irq ? 12'o4000 : w);
    step();
    bus.ckFetch = 1'b0;
    bus.irqOverride = 1'b0;
    step();
  endtask

  task automatic drain(input int n);
    bus.irTake = 1'b1;
    repeat (n) step();
    bus.irTake = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (RESET && bus.irTake && bus.irValid && !bus.flush) begin
      if (expq.size() == 0) begin
        check("unexpected_pop", 32'(bus.busIR), 32'hFFFF_FFFF);
      end else begin
        check("pop_word", 32'(bus.busIR), 32'(expq.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ckFetch = 1'b0;
    bus.irqOverride = 1'b0;
    bus.busData = '0;
    bus.irTake = 1'b0;
    bus.flush = 1'b0;
    #12;
    check("rst_count", 32'(bus.count), 0);
    check("rst_valid", 32'(bus.irValid), 0);
    check("rst_busIR", 32'(bus.busIR), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_irq", 32'(bus.irqTaken), 0);
    step();
    RESET = 1'b1;
    step();

    // single push, one-cycle visibility
    bus.ckFetch = 1'b1;
    bus.busData = 12'o1234;
    expq.push_back(12'o1234);
    step();
    bus.ckFetch = 1'b0;
    check("t1_busIR", 32'(bus.busIR), 32'(12'o1234));
    check("t1_valid", 32'(bus.irValid), 1);
    check("t1_count", 32'(bus.count), 1);
    drain(1);
    check("t1_empty", 32'(bus.count), 0);

    // held ckFetch pushes once
    bus.ckFetch = 1'b1;
    bus.busData = 12'o0011;
    expq.push_back(12'o0011);
    repeat (5) step();
    bus.ckFetch = 1'b0;
    check("t2_count", 32'(bus.count), 1);
    drain(1);

    // overfill: fifth push (an override) is dropped without irqTaken
    fetch(12'o0101, 1'b0, 1'b1);
    fetch(12'o0202, 1'b0, 1'b1);
    fetch(12'o0303, 1'b0, 1'b1);
    fetch(12'o0404, 1'b0, 1'b1);
    bus.ckFetch = 1'b1;
    bus.busData = 12'o0505;
    bus.irqOverride = 1'b1;
    step();
    bus.ckFetch = 1'b0;
    bus.irqOverride = 1'b0;
    check("t3_irq_drop", 32'(bus.irqTaken), 0);
    step();
    check("t3_full", 32'(bus.full), 1);
    check("t3_overflow", 32'(bus.overflow), 1);
    check("t3_count", 32'(bus.count), 4);
    drain(4);
    check("t3_drained", 32'(bus.count), 0);
    check("t3_sticky", 32'(bus.overflow), 1);

    // full queue, simultaneous push and pop
    fetch(12'o0606, 1'b0, 1'b1);
    fetch(12'o0707, 1'b0, 1'b1);
    fetch(12'o1010, 1'b0, 1'b1);
    fetch(12'o1111, 1'b0, 1'b1);
    bus.ckFetch = 1'b1;
    bus.busData = 12'o1212;
    bus.irTake = 1'b1;
    expq.push_back(12'o1212);
    step();
    bus.ckFetch = 1'b0;
    bus.irTake = 1'b0;
    check("t4_count", 32'(bus.count), 4);
    check("t4_full", 32'(bus.full), 1);
    drain(4);

    // interrupt override
    bus.ckFetch = 1'b1;
    bus.busData = 12'o7777;
    bus.irqOverride = 1'b1;
    expq.push_back(12'o4000);
    step();
    bus.ckFetch = 1'b0;
    bus.irqOverride = 1'b0;
    check("t5_busIR", 32'(bus.busIR), 32'(12'o4000));
    check("t5_irq", 32'(bus.irqTaken), 1);
    step();
    check("t5_irq_pulse", 32'(bus.irqTaken), 0);
    drain(1);

    // flush against a fetch edge
    fetch(12'o2121, 1'b0, 1'b1);
    fetch(12'o2222, 1'b0, 1'b1);
    fetch(12'o2323, 1'b0, 1'b1);
    check("t6_pre", 32'(bus.count), 3);
    bus.flush = 1'b1;
    bus.ckFetch = 1'b1;
    bus.busData = 12'o5555;
    expq.delete();
    step();
    bus.flush = 1'b0;
    check("t6_count", 32'(bus.count), 0);
    check("t6_valid", 32'(bus.irValid), 0);
    check("t6_overflow", 32'(bus.overflow), 0);
    check("t6_busIR", 32'(bus.busIR), 0);
    step();
    check("t6_no_late_push", 32'(bus.count), 0);
    bus.ckFetch = 1'b0;
    step();

    // mid-run reset, then ckFetch high on release pushes
    fetch(12'o3030, 1'b0, 1'b1);
    fetch(12'o3131, 1'b0, 1'b1);
    #2;
    RESET = 1'b0;
    #1;
    expq.delete();
    check("t7_rst_count", 32'(bus.count), 0);
    check("t7_rst_busIR", 32'(bus.busIR), 0);
    bus.ckFetch = 1'b1;
    bus.busData = 12'o3333;
    step();
    RESET = 1'b1;
    expq.push_back(12'o3333);
    step();
    bus.ckFetch = 1'b0;
    check("t7_count", 32'(bus.count), 1);
    check("t7_busIR", 32'(bus.busIR), 32'(12'o3333));
    check("t7_irq", 32'(bus.irqTaken), 0);
    drain(1);
    step();
    check("sb_empty", 32'(expq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
